serial_rx: RTL and testbench

//   Asynchronous serial receiver, downstream of serialtx on the same tx line.

---
 rtl/serial_rx.sv | 131 +++++++++++++
 tb/tb_serial_rx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx.sv
// Asynchronous serial receiver: 8-bit frames, MSB first, start 0 / stop 1.
// Mid-bit sampling, one-cycle rxv on a good frame, one-cycle frame_err on a bad stop bit.
module serial_rx #(
    parameter int CLKS_PER_BIT = 167,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rxv,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bidx_q, bidx_d;
    logic [7:0]       sh_q, sh_d;
    logic [7:0]       data_q, data_d;
    logic             rxv_q, rxv_d;
    logic             ferr_q, ferr_d;
    logic             rx_meta_q, rx_s_q, rx_prev_q;
    logic             start_edge;

    // Synchronizer resets low so a line held low through reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b0;
            rx_s_q    <= 1'b0;
            rx_prev_q <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign start_edge = rx_prev_q && !rx_s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bidx_q  <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            rxv_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            rxv_q   <= rxv_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bidx_d  = bidx_q;
        sh_d    = sh_q;
        data_d  = data_q;
        rxv_d   = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d  = '0;
                    bidx_d = '0;
                    // A start bit that is already high again at mid-bit is treated as a glitch.
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_M1) begin
                    sh_d   = {sh_q[6:0], rx_s_q};
                    cnt_d  = '0;
                    bidx_d = bidx_q + 3'd1;
                    if (bidx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == BIT_M1) begin
                    if (rx_s_q) begin
                        data_d = sh_q;
                        rxv_d  = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data      = data_q;
    assign rxv       = rxv_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx: directed corner cases, a vector table,
// randomized baud-skewed frames and a fast-rate 256-byte loopback on a second instance.
module tb_serial_rx;

    localparam int CPB   = 167;
    localparam int HALF  = CPB / 2;
    localparam int CPB_B = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       rxv_a, rxv_b, ferr_a, ferr_b, busy_a, busy_b;

    serial_rx #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .data(data_a),
        .rxv(rxv_a), .frame_err(ferr_a), .busy(busy_a)
    );

    serial_rx #(.CLKS_PER_BIT(CPB_B), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .data(data_b),
        .rxv(rxv_b), .frame_err(ferr_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         total = 0;
    int         bad = 0;
    logic [7:0] got_a[$];
    logic [7:0] got_b[$];
    int         ferr_n_a = 0, ferr_n_b = 0;
    int         rxv_cyc_a = 0;
    logic       rxv_a_p = 1'b0, ferr_a_p = 1'b0, rxv_b_p = 1'b0, ferr_b_p = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Pulses must be single-cycle and mutually exclusive; every rxv captures the byte.
    always @(negedge clk) begin
        if (rxv_a || ferr_a) begin
            total++;
            if ((rxv_a && ferr_a) || (rxv_a && rxv_a_p) || (ferr_a && ferr_a_p)) begin
                bad++;
                $display("FAIL pulse_a: rxv=%b ferr=%b prev rxv=%b ferr=%b, expected single exclusive pulses",
                         rxv_a, ferr_a, rxv_a_p, ferr_a_p);
            end
        end
        if (rxv_b || ferr_b) begin
            total++;
            if ((rxv_b && ferr_b) || (rxv_b && rxv_b_p) || (ferr_b && ferr_b_p)) begin
                bad++;
                $display("FAIL pulse_b: rxv=%b ferr=%b prev rxv=%b ferr=%b, expected single exclusive pulses",
                         rxv_b, ferr_b, rxv_b_p, ferr_b_p);
            end
        end
        if (rxv_a) begin
            got_a.push_back(data_a);
            rxv_cyc_a = cyc;
        end
        if (rxv_b) got_b.push_back(data_b);
        if (ferr_a) ferr_n_a++;
        if (ferr_b) ferr_n_b++;
        rxv_a_p = rxv_a;
        ferr_a_p = ferr_a;
        rxv_b_p = rxv_b;
        ferr_b_p = ferr_b;
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation exceeded its time budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic drv(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input logic stopb, input int per);
        drv(sel, 1'b0);
        hold(per);
        for (int i = 7; i >= 0; i--) begin
            drv(sel, d[i]);
            hold(per);
        end
        drv(sel, stopb);
        hold(per);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stopb;
        logic [7:0] exp_data;
        int         exp_rxv;
        int         exp_ferr;
    } vec_t;

    vec_t       tbl[6];
    int         n0, f0, bcnt, t0, per;
    logic [7:0] rd, vb;

    initial begin
        tbl[0] = '{8'h80, 1'b1, 8'h80, 1, 0};
        tbl[1] = '{8'h01, 1'b1, 8'h01, 1, 0};
        tbl[2] = '{8'h3C, 1'b0, 8'h01, 0, 1};
        tbl[3] = '{8'h55, 1'b1, 8'h55, 1, 0};
        tbl[4] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
        tbl[5] = '{8'h00, 1'b1, 8'h00, 1, 0};

        // Reset with the line low: no frame may start after release.
        rx_a = 1'b0;
        hold(5);
        chk("reset_data", data_a, 8'h00);
        chk("reset_rxv", rxv_a, 0);
        chk("reset_ferr", ferr_a, 0);
        chk("reset_busy", busy_a, 0);
        rst_n = 1'b1;
        bcnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy_a) bcnt++;
        end
        chk("low_at_release_busy", bcnt, 0);
        rx_a = 1'b1;
        hold(20);

        // Frame A5 with exact rxv timing.
        n0 = got_a.size();
        t0 = cyc;
        send(0, 8'hA5, 1'b1, CPB);
        chk("t1_rxv_count", got_a.size() - n0, 1);
        chk("t1_data", data_a, 8'hA5);
        chk("t1_rxv_cycle", rxv_cyc_a - t0, 3 + HALF + 9 * CPB);
        chk("t1_ferr", ferr_n_a, 0);
        chk("t1_busy_after", busy_a, 0);
        hold(CPB);

        for (int i = 0; i < 6; i++) begin
            n0 = got_a.size();
            f0 = ferr_n_a;
            send(0, tbl[i].d, tbl[i].stopb, CPB);
            chk($sformatf("tbl%0d_rxv", i), got_a.size() - n0, tbl[i].exp_rxv);
            chk($sformatf("tbl%0d_ferr", i), ferr_n_a - f0, tbl[i].exp_ferr);
            chk($sformatf("tbl%0d_data", i), data_a, tbl[i].exp_data);
            chk($sformatf("tbl%0d_busy", i), busy_a, 0);
            drv(0, 1'b1);
            hold(CPB);
        end

        // Back-to-back with zero gap, then with a one-bit idle gap.
        n0 = got_a.size();
        send(0, 8'h55, 1'b1, CPB);
        send(0, 8'hAA, 1'b1, CPB);
        hold(CPB);
        send(0, 8'h55, 1'b1, CPB);
        hold(CPB);
        send(0, 8'hAA, 1'b1, CPB);
        chk("b2b_count", got_a.size() - n0, 4);
        if (got_a.size() - n0 == 4) begin
            chk("b2b0_val", got_a[n0], 8'h55);
            chk("b2b1_val", got_a[n0+1], 8'hAA);
            chk("gap0_val", got_a[n0+2], 8'h55);
            chk("gap1_val", got_a[n0+3], 8'hAA);
        end
        hold(CPB);

        // Random bytes at nominal and +/-2% bit periods.
        for (int i = 0; i < 6; i++) begin
            rd = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0:       per = 164;
                1:       per = 167;
                default: per = 170;
            endcase
            n0 = got_a.size();
            send(0, rd, 1'b1, per);
            hold(CPB);
            chk($sformatf("rand%0d_count(per=%0d)", i, per), got_a.size() - n0, 1);
            chk($sformatf("rand%0d_data(per=%0d)", i, per), data_a, rd);
        end

        // Glitch: 40 low cycles must abort after exactly HALF busy cycles.
        n0 = got_a.size();
        f0 = ferr_n_a;
        bcnt = 0;
        drv(0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            if (i == 40) drv(0, 1'b1);
            @(negedge clk);
            if (busy_a) bcnt++;
        end
        chk("glitch_busy_cycles", bcnt, HALF);
        chk("glitch_rxv", got_a.size() - n0, 0);
        chk("glitch_ferr", ferr_n_a - f0, 0);
        chk("glitch_busy_end", busy_a, 0);

        // Bad stop bit followed by a long break.
        rd = data_a;
        n0 = got_a.size();
        f0 = ferr_n_a;
        send(0, 8'h3C, 1'b0, CPB);
        bcnt = 0;
        repeat (3000) begin
            @(negedge clk);
            if (busy_a) bcnt++;
        end
        chk("break_ferr", ferr_n_a - f0, 1);
        chk("break_rxv", got_a.size() - n0, 0);
        chk("break_data_kept", data_a, rd);
        chk("break_no_restart", bcnt, 0);
        drv(0, 1'b1);
        hold(CPB);
        send(0, 8'h7E, 1'b1, CPB);
        chk("after_break_data", data_a, 8'h7E);
        hold(CPB);

        // Reset during bit 4 of a frame, line then idles.
        n0 = got_a.size();
        f0 = ferr_n_a;
        vb = 8'h5A;
        drv(0, 1'b0);
        hold(CPB);
        for (int i = 7; i >= 5; i--) begin
            drv(0, vb[i]);
            hold(CPB);
        end
        drv(0, vb[4]);
        hold(CPB / 2);
        rst_n = 1'b0;
        rx_a = 1'b1;
        hold(5);
        rst_n = 1'b1;
        bcnt = 0;
        repeat (2000) begin
            @(negedge clk);
            if (busy_a) bcnt++;
        end
        chk("rst_mid_rxv", got_a.size() - n0, 0);
        chk("rst_mid_ferr", ferr_n_a - f0, 0);
        chk("rst_mid_data", data_a, 8'h00);
        chk("rst_mid_busy", bcnt, 0);
        send(0, 8'hC3, 1'b1, CPB);
        chk("after_rst_data", data_a, 8'hC3);

        // Transmitter-style loopback of every byte on the fast instance.
        for (int v = 0; v < 256; v++) begin
            vb = 8'(v);
            drv(1, 1'b1);
            hold(CPB_B);
            send(1, vb, 1'b1, CPB_B);
            if (got_b.size() != v + 1) chk($sformatf("loop%0d_count", v), got_b.size(), v + 1);
            else                       chk($sformatf("loop%0d_data", v), got_b[v], vb);
        end
        chk("loop_ferr", ferr_n_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
